// File: rtl/regfile_mp_sb_if.sv
// Bus interface for regfile_mp_sb.
//   Groups the write ports, read ports and scoreboard controls of the register file.
//   master: the pipeline side (drives writes, reads, issue and flush).
//   slave : the register file (returns read data, busy flags and busy count).
// Signals (widths follow the interface parameters):
//   we, wa, wd          packed write ports; port k uses slice k of each vector
//   re, ra              packed read enables/addresses
//   rd, rd_busy         packed read data and per-port busy flags
//   iss_valid, iss_wa   issue-time busy marking
//   flush               clears every busy bit
//   busy_cnt            registered number of busy registers
interface regfile_mp_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 4,
    parameter int unsigned NUM_WR = 2
);
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] wa;
    logic [NUM_WR*DATA_W-1:0] wd;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_wa;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output we, wa, wd, re, ra, iss_valid, iss_wa, flush,
        input  rd, rd_busy, busy_cnt
    );

    modport slave (
        input  we, wa, wd, re, ra, iss_valid, iss_wa, flush,
        output rd, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with a per-register busy scoreboard.
//   r0 reads as zero and ignores writes. Among write ports hitting the same register in one
//   cycle, the highest index wins. Issue marks the destination busy, writeback clears it,
//   flush clears everything; flush beats issue, and issue beats writeback.
// Ports:
//   cpu_clk_50M  clock, rising edge
//   cpu_rst_n    asynchronous active-low reset; also forces rd/rd_busy to 0 while held
//   bus          regfile_mp_sb_if.slave (write/read ports, issue, flush, busy_cnt)
// Configuration:
//   REGFILE_BYPASS_EN  when defined, reads forward same-cycle write data and the matching
//                      busy flag reads 0 unless the same register is being issued.
module regfile_mp_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 4,
    parameter int unsigned NUM_WR = 2
) (
    input logic            cpu_clk_50M,
    input logic            cpu_rst_n,
    regfile_mp_sb_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam int unsigned CntW    = ADDR_W + 1;

    logic [DATA_W-1:0]  regs_q [NumRegs];
    logic [DATA_W-1:0]  regs_d [NumRegs];
    logic [NumRegs-1:0] busy_q, busy_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [ADDR_W-1:0]        wa_u [NUM_WR];
    logic [DATA_W-1:0]        wd_u [NUM_WR];
    logic [ADDR_W-1:0]        ra_u [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_int;
    logic [NUM_RD-1:0]        rd_busy_int;

    // Unpack the flat port vectors.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wa_u[k] = bus.wa[k*ADDR_W +: ADDR_W];
            wd_u[k] = bus.wd[k*DATA_W +: DATA_W];
        end
        for (int j = 0; j < NUM_RD; j++) begin
            ra_u[j] = bus.ra[j*ADDR_W +: ADDR_W];
        end
    end

    // Ascending port order lets the highest-index writer win.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.we[k] && (wa_u[k] != '0)) begin
                regs_d[wa_u[k]] = wd_u[k];
            end
        end
    end

    // Applied lowest to highest priority: writeback clear, issue set, flush.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.we[k] && (wa_u[k] != '0)) begin
                busy_d[wa_u[k]] = 1'b0;
            end
        end
        if (bus.iss_valid && (bus.iss_wa != '0)) begin
            busy_d[bus.iss_wa] = 1'b1;
        end
        if (bus.flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Count is taken on the next-state vector so busy_cnt matches busy after the edge.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NumRegs; i++) begin
            cnt_d = cnt_d + CntW'(busy_d[i]);
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports. Gated by reset so forwarded write data cannot leak out while held.
    always_comb begin
        rd_int      = '0;
        rd_busy_int = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (cpu_rst_n && bus.re[j] && (ra_u[j] != '0)) begin
                rd_int[j*DATA_W +: DATA_W] = regs_q[ra_u[j]];
                rd_busy_int[j]             = busy_q[ra_u[j]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.we[k] && (wa_u[k] == ra_u[j])) begin
                        rd_int[j*DATA_W +: DATA_W] = wd_u[k];
                        // A same-cycle issue to this register is a newer producer.
                        rd_busy_int[j] = bus.iss_valid && (bus.iss_wa == ra_u[j]);
                    end
                end
`endif
            end
        end
    end

    assign bus.rd       = rd_int;
    assign bus.rd_busy  = rd_busy_int;
    assign bus.busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (default parameters).
// Table of {inputs, expected post-edge outputs} plus hand sequences for reset,
// same-cycle forwarding and scoreboard saturation.
module tb_regfile_mp_sb;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 4;
    localparam int unsigned NUM_WR = 2;

    logic cpu_clk_50M = 1'b0;
    logic cpu_rst_n   = 1'b0;

    regfile_mp_sb_if #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) bus ();

    regfile_mp_sb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .bus         (bus)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  iss_wa;
        logic        flush;
        logic        re;
        logic [4:0]  ra;
        logic [31:0] e_rd;
        logic        e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [15];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic clear_drive();
        bus.we        = '0;
        bus.wa        = '0;
        bus.wd        = '0;
        bus.iss_valid = 1'b0;
        bus.iss_wa    = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_reads(input logic en, input logic [4:0] addr);
        for (int j = 0; j < NUM_RD; j++) begin
            bus.re[j]                = en;
            bus.ra[j*ADDR_W +: ADDR_W] = addr;
        end
    endtask

    task automatic check_ports(input string name, input logic [31:0] e_rd, input logic e_busy);
        for (int j = 0; j < NUM_RD; j++) begin
            check($sformatf("%s rd%0d", name, j), bus.rd[j*DATA_W +: DATA_W], e_rd);
            check($sformatf("%s rd_busy%0d", name, j), 32'(bus.rd_busy[j]), 32'(e_busy));
        end
    endtask

    task automatic check_cnt(input string name, input logic [5:0] e_cnt);
        check($sformatf("%s busy_cnt", name), 32'(bus.busy_cnt), 32'(e_cnt));
    endtask

    initial begin
        //           we     wa0    wa1    wd0           wd1           iss   iss_wa flush re    ra     e_rd          e_bsy e_cnt
        vecs[0]  = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       1'b0, 5'd0,  1'b0, 1'b1, 5'd7,  32'h22,       1'b0, 6'd0};
        vecs[1]  = '{2'b01, 5'd0,  5'd0,  32'h55,       32'h0,        1'b0, 5'd0,  1'b0, 1'b1, 5'd0,  32'h0,        1'b0, 6'd0};
        vecs[2]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd5,  1'b0, 1'b1, 5'd5,  32'h0,        1'b1, 6'd1};
        vecs[3]  = '{2'b01, 5'd5,  5'd0,  32'hA5,       32'h0,        1'b0, 5'd0,  1'b0, 1'b1, 5'd5,  32'hA5,       1'b0, 6'd0};
        vecs[4]  = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h99,       1'b1, 5'd9,  1'b0, 1'b1, 5'd9,  32'h99,       1'b1, 6'd1};
        vecs[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd10, 1'b1, 1'b1, 5'd10, 32'h0,        1'b0, 6'd0};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd3,  1'b0, 1'b1, 5'd3,  32'h0,        1'b1, 6'd1};
        vecs[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd4,  1'b0, 1'b1, 5'd3,  32'h0,        1'b1, 6'd2};
        vecs[8]  = '{2'b11, 5'd3,  5'd4,  32'h33,       32'h44,       1'b0, 5'd0,  1'b0, 1'b1, 5'd4,  32'h44,       1'b0, 6'd0};
        vecs[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd0,  1'b0, 1'b1, 5'd3,  32'h33,       1'b0, 6'd0};
        vecs[10] = '{2'b10, 5'd0,  5'd31, 32'h0,        32'hFFFF_FFFF,1'b0, 5'd0,  1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF,1'b0, 6'd0};
        vecs[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 5'd31, 32'h0,        1'b0, 6'd0};
        vecs[12] = '{2'b11, 5'd12, 5'd13, 32'hC,        32'hD,        1'b0, 5'd0,  1'b0, 1'b1, 5'd12, 32'hC,        1'b0, 6'd0};
        vecs[13] = '{2'b01, 5'd12, 5'd0,  32'hCC,       32'h0,        1'b1, 5'd12, 1'b0, 1'b1, 5'd12, 32'hCC,       1'b1, 6'd1};
        vecs[14] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 1'b1, 5'd12, 32'hCC,       1'b0, 6'd0};

        clear_drive();
        set_reads(1'b1, 5'd7);

        // Reset held from time zero.
        #15;
        check_cnt("por", 6'd0);
        check_ports("por", 32'h0, 1'b0);
        #20;
        cpu_rst_n = 1'b1;
        tick();

        // Table: drive, clock, release the drivers, then check read ports and busy_cnt.
        for (int v = 0; v < 15; v++) begin
            bus.we        = vecs[v].we;
            bus.wa        = {vecs[v].wa1, vecs[v].wa0};
            bus.wd        = {vecs[v].wd1, vecs[v].wd0};
            bus.iss_valid = vecs[v].iss;
            bus.iss_wa    = vecs[v].iss_wa;
            bus.flush     = vecs[v].flush;
            tick();
            clear_drive();
            set_reads(vecs[v].re, vecs[v].ra);
            #1;
            check_ports($sformatf("vec%0d", v), vecs[v].e_rd, vecs[v].e_busy);
            check_cnt($sformatf("vec%0d", v), vecs[v].e_cnt);
        end

        // Same-cycle writeback to a busy register.
        bus.we = 2'b01; bus.wa = {5'd0, 5'd4}; bus.wd = {32'h0, 32'h0BAD};
        tick();
        clear_drive();
        bus.iss_valid = 1'b1; bus.iss_wa = 5'd4;
        tick();
        clear_drive();
        set_reads(1'b1, 5'd4);
        bus.we = 2'b01; bus.wa = {5'd0, 5'd4}; bus.wd = {32'h0, 32'h1234};
        #1;
`ifdef REGFILE_BYPASS_EN
        check_ports("wb_same", 32'h1234, 1'b0);
`else
        check_ports("wb_same", 32'h0BAD, 1'b1);
`endif
        tick();
        clear_drive();
        #1;
        check_ports("wb_next", 32'h1234, 1'b0);
        check_cnt("wb_next", 6'd0);

        // Two writers plus an issue, all on r4.
        bus.we = 2'b11; bus.wa = {5'd4, 5'd4}; bus.wd = {32'h2, 32'h1};
        bus.iss_valid = 1'b1; bus.iss_wa = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_ports("wb_iss_same", 32'h2, 1'b1);
`else
        check_ports("wb_iss_same", 32'h1234, 1'b0);
`endif
        tick();
        clear_drive();
        #1;
        check_ports("wb_iss_next", 32'h2, 1'b1);
        check_cnt("wb_iss_next", 6'd1);

        // Saturate the scoreboard.
        for (int i = 1; i < 32; i++) begin
            bus.iss_valid = 1'b1;
            bus.iss_wa    = 5'(i);
            tick();
        end
        clear_drive();
        set_reads(1'b1, 5'd17);
        #1;
        check_cnt("fill", 6'd31);
        check_ports("fill", 32'h0, 1'b1);
        bus.iss_valid = 1'b1; bus.iss_wa = 5'd0;
        tick();
        clear_drive();
        #1;
        check_cnt("iss_r0", 6'd31);

        // Asynchronous reset in the middle of a write and an issue.
        bus.we = 2'b01; bus.wa = {5'd0, 5'd3}; bus.wd = {32'h0, 32'hDEAD_BEEF};
        bus.iss_valid = 1'b1; bus.iss_wa = 5'd6;
        set_reads(1'b1, 5'd3);
        #5;
        cpu_rst_n = 1'b0;
        #1;
        check_cnt("rst_held", 6'd0);
        check_ports("rst_held", 32'h0, 1'b0);
        #2;
        clear_drive();
        #3;
        cpu_rst_n = 1'b1;
        tick();
        check_ports("rst_r3", 32'h0, 1'b0);
        check_cnt("rst_after", 6'd0);
        set_reads(1'b1, 5'd4);
        #1;
        check_ports("rst_r4", 32'h0, 1'b0);
        set_reads(1'b1, 5'd6);
        #1;
        check_ports("rst_r6", 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
